// File: rtl/mem_arb_pkg.sv
// Shared types and bus widths for the LeoSoC memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_t;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = 4;

  // Width of a port index; a single port still needs one bit to hold it.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin search: first claiming port strictly after i_last, wrapping around.
module rr_priority_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] i_claim,
  input  logic [IDX_W-1:0]     i_last,
  output logic [NUM_PORTS-1:0] o_onehot,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    // k = NUM_PORTS revisits i_last itself, so it is the lowest priority.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!o_valid && i_claim[(int'(i_last) + k) % NUM_PORTS]) begin
        o_valid = 1'b1;
        o_onehot[(int'(i_last) + k) % NUM_PORTS] = 1'b1;
        o_idx = IDX_W'((int'(i_last) + k) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between NUM_PORTS requesters,
// holding each grant until mem_done, abort or watchdog expiry.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MEM_ADDR_W*NUM_PORTS-1:0] req_addr,
  input  logic [MEM_DATA_W*NUM_PORTS-1:0] req_wdata,
  input  logic [MEM_MASK_W*NUM_PORTS-1:0] req_wmask,
  input  logic [NUM_PORTS-1:0]            req_wstrb,
  input  logic [NUM_PORTS-1:0]            req_rstrb,
  output logic [NUM_PORTS-1:0]            req_done,
  output logic [MEM_DATA_W-1:0]           req_rdata,
  output logic [MEM_ADDR_W-1:0]           mem_addr,
  output logic [MEM_DATA_W-1:0]           mem_wdata,
  output logic [MEM_MASK_W-1:0]           mem_wmask,
  output logic                            mem_wstrb,
  output logic                            mem_rstrb,
  input  logic [MEM_DATA_W-1:0]           mem_rdata,
  input  logic                            mem_done,
  output logic [NUM_PORTS-1:0]            granted,
  output logic                            busy,
  output logic                            timeout
);

  localparam int IDX_W = idx_w(NUM_PORTS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t           r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_last;

  logic [NUM_PORTS-1:0] w_claim;
  logic [NUM_PORTS-1:0] w_win;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_win_vld;
  logic                 w_held;
  logic                 w_expire;
  logic                 w_release;

  assign w_claim = req_rstrb | req_wstrb;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .i_claim  (w_claim),
    .i_last   (r_last),
    .o_onehot (w_win),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_vld)
  );

  // The granted port still holds a strobe; dropping both is an abort.
  assign w_held    = |(w_claim & r_grant);
  assign w_release = (r_state == ARB_BUSY) && (mem_done || !w_held || w_expire);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (reset)
          r_cnt <= '0;
        else if (r_state == ARB_IDLE)
          r_cnt <= '0;
        else if (r_cnt != CNT_W'(TIMEOUT_CYCLES))
          r_cnt <= r_cnt + 1'b1;
      end

      // Fires in the BUSY cycle whose increment reaches TIMEOUT_CYCLES;
      // a simultaneous mem_done wins and is treated as a normal completion.
      assign w_expire = (r_state == ARB_BUSY) && !mem_done &&
                        (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wdog
      assign w_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_last  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_win_vld) begin
            r_state <= ARB_BUSY;
            r_grant <= w_win;
            r_idx   <= w_win_idx;
          end
        end
        ARB_BUSY: begin
          if (w_release) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= r_idx;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // AND-OR mux on the one-hot grant; an empty grant yields an all-zero bus.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) begin
        mem_addr  = mem_addr  | req_addr [MEM_ADDR_W*i +: MEM_ADDR_W];
        mem_wdata = mem_wdata | req_wdata[MEM_DATA_W*i +: MEM_DATA_W];
        mem_wmask = mem_wmask | req_wmask[MEM_MASK_W*i +: MEM_MASK_W];
      end
    end
  end

  assign mem_wstrb = |(req_wstrb & r_grant);
  assign mem_rstrb = |(req_rstrb & r_grant);
  assign req_done  = r_grant & {NUM_PORTS{mem_done}};
  assign req_rdata = mem_rdata;
  assign granted   = r_grant;
  assign busy      = (r_state == ARB_BUSY);
  assign timeout   = w_expire;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two ports, watchdog of 4 cycles.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic [1:0]  req_wstrb, req_rstrb;
  logic [1:0]  req_done;
  logic [31:0] req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrb, mem_rstrb, mem_done;
  logic [1:0]  granted;
  logic        busy, timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NUM_PORTS(2), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .req_wstrb(req_wstrb), .req_rstrb(req_rstrb),
    .req_done(req_done), .req_rdata(req_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .granted(granted), .busy(busy), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    req_wstrb = '0;
    req_rstrb = '0;
    mem_rdata = '0;
    mem_done  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [1:0] fair_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10};

  initial begin
    #200000;
    $display("FAIL run_timeout: got no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset state, then a single read from port 0
    do_reset();
    #1;
    chk("rst_granted", 32'(granted), 0);
    chk("rst_busy",    32'(busy),    0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_addr",    mem_addr,     0);
    chk("rst_done",    32'(req_done), 0);

    req_rstrb       = 2'b01;
    req_addr[31:0]  = 32'h100;
    mem_done        = 1'b1;   // done while idle must be ignored
    #1;
    chk("idle_gnt",  32'(granted),  0);
    chk("idle_done", 32'(req_done), 0);
    step();
    mem_done = 1'b0;
    #1;
    chk("sr_gnt",   32'(granted),   1);
    chk("sr_addr",  mem_addr,       32'h100);
    chk("sr_rstrb", 32'(mem_rstrb), 1);
    chk("sr_busy",  32'(busy),      1);
    step();
    step();
    step();
    // 4th BUSY cycle: done coincides with watchdog expiry, completion wins
    mem_done  = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    chk("sr_done",    32'(req_done), 1);
    chk("sr_rdata",   req_rdata,     32'h1234_5678);
    chk("sr_no_tmo",  32'(timeout),  0);
    step();
    mem_done  = 1'b0;
    req_rstrb = 2'b00;
    #1;
    chk("sr_clr_gnt",  32'(granted), 0);
    chk("sr_clr_busy", 32'(busy),    0);
    chk("sr_clr_addr", mem_addr,     0);

    // Fairness: both ports claim continuously, done 2 cycles after grant
    do_reset();
    req_rstrb       = 2'b11;
    req_addr[31:0]  = 32'h200;
    req_addr[63:32] = 32'h300;
    for (int c = 0; c < 14; c++) begin
      mem_done = (c % 4 == 3);
      #1;
      chk($sformatf("fair_gnt%0d", c), 32'(granted), 32'(fair_exp[c % 8]));
      chk($sformatf("fair_done%0d", c), 32'(req_done),
          (c % 4 == 3) ? 32'(fair_exp[c % 8]) : 32'd0);
      if (c == 5) chk("fair_addr1", mem_addr, 32'h300);
      if (c == 9) chk("fair_addr0", mem_addr, 32'h200);
      step();
    end
    mem_done  = 1'b0;
    req_rstrb = 2'b00;

    // Write routing from port 1
    do_reset();
    req_wstrb        = 2'b10;
    req_wdata[63:32] = 32'hDEAD_BEEF;
    req_wmask[7:4]   = 4'hC;
    req_addr[63:32]  = 32'h400;
    step();
    #1;
    chk("wr_gnt",   32'(granted),   2);
    chk("wr_wdata", mem_wdata,      32'hDEAD_BEEF);
    chk("wr_wmask", 32'(mem_wmask), 32'hC);
    chk("wr_wstrb", 32'(mem_wstrb), 1);
    chk("wr_rstrb", 32'(mem_rstrb), 0);
    chk("wr_addr",  mem_addr,       32'h400);
    step();
    mem_done = 1'b1;
    #1;
    chk("wr_done", 32'(req_done), 2);
    step();
    mem_done  = 1'b0;
    req_wstrb = 2'b00;
    #1;
    chk("wr_clr_gnt",   32'(granted), 0);
    chk("wr_clr_wdata", mem_wdata,    0);

    // Abort: granted port drops its strobe without mem_done
    do_reset();
    req_rstrb = 2'b01;
    step();
    #1;
    chk("ab_gnt", 32'(granted), 1);
    req_rstrb = 2'b00;
    #1;
    chk("ab_done",  32'(req_done),  0);
    chk("ab_rstrb", 32'(mem_rstrb), 0);
    step();
    #1;
    chk("ab_clr_gnt",  32'(granted), 0);
    chk("ab_clr_busy", 32'(busy),    0);

    // Watchdog: no mem_done, port 1 waiting
    do_reset();
    req_rstrb = 2'b11;
    step();
    #1;
    chk("wd_gnt0", 32'(granted), 1);
    step();
    step();
    #1;
    chk("wd_tmo_early", 32'(timeout), 0);
    step();
    #1;
    chk("wd_tmo",      32'(timeout),  1);
    chk("wd_tmo_gnt",  32'(granted),  1);
    chk("wd_tmo_done", 32'(req_done), 0);
    step();
    req_rstrb = 2'b10;
    #1;
    chk("wd_drop_gnt", 32'(granted), 0);
    chk("wd_drop_tmo", 32'(timeout), 0);
    step();
    #1;
    chk("wd_next_gnt", 32'(granted), 2);
    mem_done = 1'b1;
    step();
    mem_done  = 1'b0;
    req_rstrb = 2'b00;

    // Reset mid-write
    do_reset();
    req_wstrb       = 2'b01;
    req_wdata[31:0] = 32'hCAFE_F00D;
    step();
    #1;
    chk("rw_gnt",   32'(granted),   1);
    chk("rw_wstrb", 32'(mem_wstrb), 1);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_rstrb = 2'b10;
    #1;
    chk("rw_rst_gnt",   32'(granted),   0);
    chk("rw_rst_wstrb", 32'(mem_wstrb), 0);
    chk("rw_rst_wdata", mem_wdata,      0);
    chk("rw_rst_busy",  32'(busy),      0);
    chk("rw_rst_done",  32'(req_done),  0);
    step();
    #1;
    chk("rw_first_gnt", 32'(granted), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
